// File: rtl/mau_pkg.sv
// Shared definitions for the data-memory access unit: size codes, FSM states,
// lane geometry and the alignment check.
package mau_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    localparam int LANE_W = 8;
    localparam int HALF_W = 16;
    localparam int WORD_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ   = 3'd1,
        ST_WSETUP = 3'd2,
        ST_WRITE  = 3'd3,
        ST_RESP   = 3'd4
    } mau_state_t;

    // Reserved size is reported separately; this only checks natural alignment.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_HALF: return addr_lo[0];
            SZ_WORD: return addr_lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mau_lane_align.sv
// Little-endian lane steering: extracts and extends load data, and merges
// sub-word store data into a full word for read-modify-write.
module mau_lane_align
    import mau_pkg::*;
(
    input  logic [1:0]        i_size,
    input  logic              i_signed,
    input  logic [1:0]        i_addr_lo,
    input  logic [WORD_W-1:0] i_word,
    input  logic [HALF_W-1:0] i_wdata,
    output logic [WORD_W-1:0] o_load_data,
    output logic [WORD_W-1:0] o_merged
);

    logic [4:0]        w_shamt;
    logic [HALF_W-1:0] w_shifted;
    logic [WORD_W-1:0] w_mask;
    logic [WORD_W-1:0] w_ins;

    assign w_shamt   = {i_addr_lo, 3'b000};
    assign w_shifted = HALF_W'(i_word >> w_shamt);

    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        o_load_data = i_word;
        w_mask      = '0;
        w_ins       = '0;
        case (i_size)
            SZ_BYTE: begin
                o_load_data = {{(WORD_W-LANE_W){i_signed & w_shifted[LANE_W-1]}}, w_shifted[LANE_W-1:0]};
                w_mask      = {{(WORD_W-LANE_W){1'b0}}, {LANE_W{1'b1}}} << w_shamt;
                w_ins       = {{(WORD_W-LANE_W){1'b0}}, i_wdata[LANE_W-1:0]} << w_shamt;
            end
            SZ_HALF: begin
                o_load_data = {{(WORD_W-HALF_W){i_signed & w_shifted[HALF_W-1]}}, w_shifted};
                w_mask      = {{(WORD_W-HALF_W){1'b0}}, {HALF_W{1'b1}}} << w_shamt;
                w_ins       = {{(WORD_W-HALF_W){1'b0}}, i_wdata} << w_shamt;
            end
            default: ;
        endcase
        o_merged = (i_word & ~w_mask) | (w_ins & w_mask);
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator for the word-only DataMem port; sub-word stores use
// read-modify-write. Define MAU_STATS_EN to add saturating completion counters.
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32,
    parameter int STAT_W = 16
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              MemRead,
    output logic              MemWrite,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] write_data,
    input  logic [DATA_W-1:0] read_data
`ifdef MAU_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_loads,
    output logic [STAT_W-1:0] stat_stores,
    output logic [STAT_W-1:0] stat_faults
`endif
);

    mau_state_t        r_state;
    logic              r_write;
    logic [1:0]        r_size;
    logic              r_signed;
    logic [1:0]        r_addr_lo;
    logic [HALF_W-1:0] r_wdata;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_write_data;
    logic [DATA_W-1:0] r_resp_rdata;
    logic              r_resp_err;

    logic              w_accept;
    logic              w_fault;
    logic [DATA_W-1:0] w_load_data;
    logic [DATA_W-1:0] w_merged;

    assign req_ready  = (r_state == ST_IDLE);
    assign w_accept   = req_valid && req_ready;
    assign w_fault    = (req_size == SZ_RSVD) || is_misaligned(req_size, req_addr[1:0]);

    assign MemRead    = (r_state == ST_READ);
    assign MemWrite   = (r_state == ST_WRITE);
    assign resp_valid = (r_state == ST_RESP);
    assign addr       = r_addr;
    assign write_data = r_write_data;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;

    // read_data is used live during READ: the load result and the merged
    // store word are both registered on the edge that ends READ.
    mau_lane_align u_lane_align (
        .i_size      (r_size),
        .i_signed    (r_signed),
        .i_addr_lo   (r_addr_lo),
        .i_word      (read_data),
        .i_wdata     (r_wdata),
        .o_load_data (w_load_data),
        .o_merged    (w_merged)
    );

    // NOTE: request capture registers need no reset; they are always written on accept before any state reads them.
    always_ff @(posedge Clk) begin
        if (w_accept) begin
            r_write   <= req_write;
            r_size    <= req_size;
            r_signed  <= req_signed;
            r_addr_lo <= req_addr[1:0];
            r_wdata   <= req_wdata[HALF_W-1:0];
        end
    end

    // NOTE: non-blocking assignments in clocked blocks, so every register sees pre-edge values.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state      <= ST_IDLE;
            r_addr       <= '0;
            r_write_data <= '0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_fault) begin
                            r_resp_rdata <= '0;
                            r_resp_err   <= 1'b1;
                            r_state      <= ST_RESP;
                        end else begin
                            r_addr <= {req_addr[ADDR_W-1:2], 2'b00};
                            if (req_write && req_size == SZ_WORD) begin
                                r_write_data <= req_wdata;
                                r_state      <= ST_WSETUP;
                            end else begin
                                r_state <= ST_READ;
                            end
                        end
                    end
                end
                ST_READ: begin
                    if (r_write) begin
                        r_write_data <= w_merged;
                        r_state      <= ST_WSETUP;
                    end else begin
                        r_resp_rdata <= w_load_data;
                        r_resp_err   <= 1'b0;
                        r_state      <= ST_RESP;
                    end
                end
                ST_WSETUP: r_state <= ST_WRITE;
                ST_WRITE: begin
                    r_resp_rdata <= '0;
                    r_resp_err   <= 1'b0;
                    r_state      <= ST_RESP;
                end
                ST_RESP:  r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef MAU_STATS_EN
    logic [STAT_W-1:0] r_stat_loads;
    logic [STAT_W-1:0] r_stat_stores;
    logic [STAT_W-1:0] r_stat_faults;

    assign stat_loads  = r_stat_loads;
    assign stat_stores = r_stat_stores;
    assign stat_faults = r_stat_faults;

    // A fault is classed as a fault regardless of whether it was a load or store.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_stat_loads  <= '0;
            r_stat_stores <= '0;
            r_stat_faults <= '0;
        end else if (r_state == ST_RESP) begin
            if (r_resp_err) begin
                if (r_stat_faults != '1) r_stat_faults <= r_stat_faults + 1'b1;
            end else if (r_write) begin
                if (r_stat_stores != '1) r_stat_stores <= r_stat_stores + 1'b1;
            end else begin
                if (r_stat_loads != '1) r_stat_loads <= r_stat_loads + 1'b1;
            end
        end
    end
`endif

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Initiator side of the data-memory interface. Accepts load/store requests from the execute/memory pipeline stage and drives the DataMem port signals MemRead, MemWrite, addr and write_data. Samples read_data and returns an aligned, sign/zero-extended load result or a store completion. Performs byte and halfword stores by read-modify-write, because DataMem only writes full words.

Parameters:
ADDR_W, 9, byte-address width (word index = addr[ADDR_W-1:2])
DATA_W, 32, data width; only 32 is supported
STAT_W, 16, width of statistics counters (used only with MAU_STATS_EN)

Ports:
Clk  input  1  system clock, rising edge
Rst  input  1  synchronous reset, active-high
req_valid  input  1  request present
req_ready  output  1  unit can accept a request (high only in IDLE)
req_write  input  1  1 = store, 0 = load
req_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as fault)
req_signed  input  1  sign-extend load result
req_addr  input  ADDR_W  byte address
req_wdata  input  DATA_W  store data, right-justified
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  DATA_W  load result (0 for stores and faults)
resp_err  output  1  misaligned or reserved-size fault
MemRead  output  1  to DataMem
MemWrite  output  1  to DataMem
addr  output  ADDR_W  to DataMem, bits [1:0] always 00
write_data  output  DATA_W  to DataMem
read_data  input  DATA_W  from DataMem

Behaviour:
- One clock (Clk); synchronous active-high reset (Rst).
- Reset state:
  - FSM in IDLE.
  - MemRead = MemWrite = 0; addr = 0; write_data = 0.
  - resp_valid = 0, resp_rdata = 0, resp_err = 0.
  - Stats counters = 0.
- Accept on the rising edge where req_valid && req_ready. All request fields are captured into registers on that edge. req_ready = (state == IDLE).
- FSM states: IDLE, READ, WSETUP, WRITE, RESP.
- MemRead and MemWrite are decoded from the state register only:
  - MemRead = 1 in READ.
  - MemWrite = 1 in WRITE.
- State transitions from IDLE on accept:
  - Fault (misaligned or size 11) -> RESP with err set.
  - Load -> READ.
  - Word store -> WSETUP.
  - Byte/half store -> READ.
- READ -> RESP for a load, or -> WSETUP for a store. read_data is captured at the end of the READ cycle.
- WSETUP -> WRITE -> RESP. RESP -> IDLE.
- DataMem write timing: addr and write_data are loaded in WSETUP and held stable through WRITE and the following cycle. MemWrite is high for exactly one cycle.
- Latency from accept edge to the resp_valid cycle:
  - Load: 2.
  - Word store: 3.
  - Sub-word store: 4.
  - Fault: 1.
- Alignment rules:
  - Halfword requires addr[0] = 0.
  - Word requires addr[1:0] = 0.
  - A faulting request never asserts MemRead or MemWrite.
- Little-endian byte lanes: lane k = bits [8k+7:8k], selected by addr[1:0].
  - Loads: shift the selected lane(s) to bit 0, then sign- or zero-extend per req_signed. req_signed is ignored for word loads.
  - Sub-word store: merge req_wdata[7:0] or [15:0] into the captured word at the addressed lane(s). All other lanes are unchanged.
- resp_valid is a one-cycle pulse with no backpressure. resp_rdata and resp_err are valid only with resp_valid and hold their value until the next response.
- Rst asserted in any state:
  - FSM returns to IDLE on that edge.
  - MemRead/MemWrite are 0 from the next cycle.
  - The in-flight request is dropped and no response is issued.
  - A partially merged store never reaches memory unless WRITE had already occurred.
- req_valid while not ready is ignored. The requester must hold it.

Optional Feature:
MAU_STATS_EN:
- Defined: adds output ports stat_loads, stat_stores and stat_faults, each STAT_W bits. Each counter increments by 1 in the RESP cycle of the matching completion and saturates at all-ones. All are cleared by Rst.
- Undefined: these ports and counters do not exist. Functional behaviour is identical.

Decomposition:
- Package mau_pkg contains:
  - Size encodings: SZ_BYTE, SZ_HALF, SZ_WORD.
  - State enum.
  - Lane-width constants.
  - Function is_misaligned(size, addr_lo).
- One combinational sub-module, mau_lane_align, does load extract/extend and store merge. The FSM and registers stay in mem_access_unit.

Test Plan:
1. Word store 0xDEADBEEF to 0x010, then word load from 0x010:
   - Store: addr = 0x010; MemWrite high exactly 1 cycle; resp_valid 3 cycles after accept.
   - Load: resp_rdata = 0xDEADBEEF, resp_valid 2 cycles after accept, resp_err = 0.
2. With 0xDEADBEEF at 0x010, sub-word loads:
   - Signed byte at 0x013 -> 0xFFFFFFDE.
   - Unsigned byte at 0x013 -> 0x000000DE.
   - Signed half at 0x012 -> 0xFFFFDEAD.
   - Unsigned half at 0x010 -> 0x0000BEEF.
3. Byte store 0x55 to 0x011, then word load from 0x010:
   - Store: MemRead pulse precedes MemWrite pulse; addr = 0x010 for both; response 4 cycles after accept.
   - Load returns 0xDEAD55EF.
4. Faulting requests (half at 0x011, word at 0x012, size 11 at 0x000):
   - resp_valid 1 cycle after accept, resp_err = 1, resp_rdata = 0.
   - MemRead and MemWrite stay 0.
5. Rst asserted during the WRITE cycle of a word store:
   - MemWrite = 0 next cycle; no resp_valid.
   - req_ready = 1 after reset; a following load completes normally.
6. With MAU_STATS_EN, issue 3 loads, 2 stores and 1 fault:
   - stat_loads = 3, stat_stores = 2, stat_faults = 1.
   - With STAT_W = 2, 5 loads -> stat_loads saturates at 3.
